// File: rtl/add_err_pkg.sv
// rtl/add_err_pkg.sv - shared widths, error type and saturating adder for add_err_monitor
package add_err_pkg;

   localparam int W_DEF     = 12;
   localparam int CNT_W_DEF = 32;
   localparam int ACC_W_DEF = 48;

   // Widest statistic the saturating adder can serve (sse is 2*ACC_W bits).
   localparam int SAT_W = 128;

   // Signed error (approx - exact) at the default operand width.
   typedef logic signed [W_DEF+1:0] err_t;

   // Adds two zero-extended values and clamps the result at the all-ones
   // value of a w-bit field; ovf reports that the clamp was applied.
   function automatic logic [SAT_W-1:0] sat_add(
      input  logic [SAT_W-1:0] a,
      input  logic [SAT_W-1:0] b,
      input  int               w,
      output logic             ovf
   );
      logic [SAT_W:0] sum;
      logic [SAT_W:0] max;
      sum = {1'b0, a} + {1'b0, b};
      if (w >= SAT_W) begin
         max = {1'b0, {SAT_W{1'b1}}};
      end else begin
         max = ((SAT_W+1)'(1) << w) - (SAT_W+1)'(1);
      end
      ovf     = (sum > max);
      sat_add = ovf ? max[SAT_W-1:0] : sum[SAT_W-1:0];
   endfunction

endpackage

// File: rtl/add_err_absdiff.sv
// rtl/add_err_absdiff.sv - combinational signed difference and absolute error
//
// Ports:
//   exact_i  [W:0]    exact sum a+b
//   approx_i [W:0]    approximate sum under test
//   diff_o   [W+1:0]  two's-complement approx - exact
//   abs_o    [W:0]    |approx - exact|
module add_err_absdiff
   import add_err_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic [W:0]   exact_i,
   input  logic [W:0]   approx_i,
   output logic [W+1:0] diff_o,
   output logic [W:0]   abs_o
);

   assign diff_o = {1'b0, approx_i} - {1'b0, exact_i};

   // Subtract in the non-negative direction so the magnitude never needs
   // the extra sign bit.
   assign abs_o = (exact_i > approx_i) ? (exact_i - approx_i)
                                       : (approx_i - exact_i);

endmodule

// File: rtl/add_err_monitor.sv
// rtl/add_err_monitor.sv - streaming error-statistics monitor for approximate adders
//
// Optional feature macro: ADD_ERR_MON_MSE_EN (adds sse output and squarer).
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  sample handshake; in_ready = !clear, 0 in reset
//   in_a, in_b [W-1:0]   operands
//   in_o [W:0]           approximate sum under test
//   clear                one-cycle pulse: zero statistics, flush pipeline
//   sample_cnt, err_cnt  samples retired / samples with nonzero error
//   wce [W:0]            worst-case absolute error
//   sae [ACC_W-1:0]      sum of absolute errors
//   last_err [W+1:0]     signed error of most recently retired sample
//   busy                 a sample is in flight
//   sat                  sticky saturation flag
//   sse [2*ACC_W-1:0]    sum of squared errors (ADD_ERR_MON_MSE_EN only)
module add_err_monitor
   import add_err_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W:0]       in_o,
   input  logic             clear,
   output logic [CNT_W-1:0] sample_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [W:0]       wce,
   output logic [ACC_W-1:0] sae,
   output logic [W+1:0]     last_err,
   output logic             busy,
   output logic             sat
`ifdef ADD_ERR_MON_MSE_EN
   ,
   output logic [2*ACC_W-1:0] sse
`endif
);

   logic transfer;

   // stage 1
   logic [W:0] exact_q;
   logic [W:0] o_q;
   logic       v1_q;

   // stage 2
   logic [W+1:0] diff;
   logic [W:0]   abs_err;
   logic [W+1:0] d_q;
   logic [W:0]   e_q;
   logic         v2_q;

   // statistics
   logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
   logic [CNT_W-1:0] err_cnt_q,    err_cnt_d;
   logic [W:0]       wce_q,        wce_d;
   logic [ACC_W-1:0] sae_q,        sae_d;
   logic [W+1:0]     last_err_q,   last_err_d;
   logic             sat_q,        sat_d;

   logic ovf_smp;
   logic ovf_err;
   logic ovf_sae;

`ifdef ADD_ERR_MON_MSE_EN
   logic [2*W+1:0]     sq_q;
   logic [2*ACC_W-1:0] sse_q, sse_d;
   logic               ovf_sse;
`endif

   // Reset holds in_ready low even though the clear input may be idle.
   assign in_ready = rst_n & ~clear;
   assign transfer = in_valid & in_ready;

   add_err_absdiff #(
      .W (W)
   ) u_absdiff (
      .exact_i  (exact_q),
      .approx_i (o_q),
      .diff_o   (diff),
      .abs_o    (abs_err)
   );

   always_comb begin
      sample_cnt_d = sample_cnt_q;
      err_cnt_d    = err_cnt_q;
      wce_d        = wce_q;
      sae_d        = sae_q;
      last_err_d   = last_err_q;
      sat_d        = sat_q;
      ovf_smp      = 1'b0;
      ovf_err      = 1'b0;
      ovf_sae      = 1'b0;
`ifdef ADD_ERR_MON_MSE_EN
      sse_d        = sse_q;
      ovf_sse      = 1'b0;
`endif
      if (v2_q) begin
         sample_cnt_d = CNT_W'(sat_add(SAT_W'(sample_cnt_q), SAT_W'(1), CNT_W, ovf_smp));
         err_cnt_d    = CNT_W'(sat_add(SAT_W'(err_cnt_q), SAT_W'(e_q != '0), CNT_W, ovf_err));
         sae_d        = ACC_W'(sat_add(SAT_W'(sae_q), SAT_W'(e_q), ACC_W, ovf_sae));
         wce_d        = (e_q > wce_q) ? e_q : wce_q;
         last_err_d   = d_q;
`ifdef ADD_ERR_MON_MSE_EN
         sse_d        = (2*ACC_W)'(sat_add(SAT_W'(sse_q), SAT_W'(sq_q), 2*ACC_W, ovf_sse));
         sat_d        = sat_q | ovf_smp | ovf_err | ovf_sae | ovf_sse;
`else
         sat_d        = sat_q | ovf_smp | ovf_err | ovf_sae;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exact_q      <= '0;
         o_q          <= '0;
         v1_q         <= 1'b0;
         d_q          <= '0;
         e_q          <= '0;
         v2_q         <= 1'b0;
         sample_cnt_q <= '0;
         err_cnt_q    <= '0;
         wce_q        <= '0;
         sae_q        <= '0;
         last_err_q   <= '0;
         sat_q        <= 1'b0;
`ifdef ADD_ERR_MON_MSE_EN
         sq_q         <= '0;
         sse_q        <= '0;
`endif
      end else begin
         if (transfer) begin
            exact_q <= {1'b0, in_a} + {1'b0, in_b};
            o_q     <= in_o;
         end
         if (v1_q) begin
            d_q  <= diff;
            e_q  <= abs_err;
`ifdef ADD_ERR_MON_MSE_EN
            sq_q <= (2*W+2)'(abs_err) * (2*W+2)'(abs_err);
`endif
         end
         // clear wins over a retire landing on the same edge.
         if (clear) begin
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            wce_q        <= '0;
            sae_q        <= '0;
            last_err_q   <= '0;
            sat_q        <= 1'b0;
`ifdef ADD_ERR_MON_MSE_EN
            sse_q        <= '0;
`endif
         end else begin
            v1_q         <= transfer;
            v2_q         <= v1_q;
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            wce_q        <= wce_d;
            sae_q        <= sae_d;
            last_err_q   <= last_err_d;
            sat_q        <= sat_d;
`ifdef ADD_ERR_MON_MSE_EN
            sse_q        <= sse_d;
`endif
         end
      end
   end

   assign sample_cnt = sample_cnt_q;
   assign err_cnt    = err_cnt_q;
   assign wce        = wce_q;
   assign sae        = sae_q;
   assign last_err   = last_err_q;
   assign busy       = v1_q | v2_q;
   assign sat        = sat_q;
`ifdef ADD_ERR_MON_MSE_EN
   assign sse        = sse_q;
`endif

endmodule

// File: tb/tb_add_err_monitor.sv
// tb/tb_add_err_monitor.sv - directed self-checking bench for add_err_monitor
module tb_add_err_monitor;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [11:0] in_a;
   logic [11:0] in_b;
   logic [12:0] in_o;
   logic        clear;

   logic        in_ready;
   logic [31:0] sample_cnt;
   logic [31:0] err_cnt;
   logic [12:0] wce;
   logic [47:0] sae;
   logic [13:0] last_err;
   logic        busy;
   logic        sat;

   logic        in_ready4;
   logic [3:0]  sample_cnt4;
   logic [3:0]  err_cnt4;
   logic [12:0] wce4;
   logic [47:0] sae4;
   logic [13:0] last_err4;
   logic        busy4;
   logic        sat4;

`ifdef ADD_ERR_MON_MSE_EN
   logic [95:0] sse;
   logic [95:0] sse4;
`endif

   int checks;
   int errors;

   add_err_monitor dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_o       (in_o),
      .clear      (clear),
      .sample_cnt (sample_cnt),
      .err_cnt    (err_cnt),
      .wce        (wce),
      .sae        (sae),
      .last_err   (last_err),
      .busy       (busy),
      .sat        (sat)
`ifdef ADD_ERR_MON_MSE_EN
      ,
      .sse        (sse)
`endif
   );

   add_err_monitor #(
      .CNT_W (4)
   ) dut4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready4),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_o       (in_o),
      .clear      (clear),
      .sample_cnt (sample_cnt4),
      .err_cnt    (err_cnt4),
      .wce        (wce4),
      .sae        (sae4),
      .last_err   (last_err4),
      .busy       (busy4),
      .sat        (sat4)
`ifdef ADD_ERR_MON_MSE_EN
      ,
      .sse        (sse4)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic send(input logic [11:0] a, input logic [11:0] b, input logic [12:0] o);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_o     = o;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_clear;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
   endtask

   task automatic drain;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n    = 1'b0;
      clear    = 1'b0;
      in_valid = 1'b1;
      in_a     = 12'd7;
      in_b     = 12'd9;
      in_o     = 13'd1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0h exp 0", in_ready); end
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL reset_sample_cnt got %0d exp 0", sample_cnt); end
      checks++; if (err_cnt !== 32'd0) begin errors++; $display("FAIL reset_err_cnt got %0d exp 0", err_cnt); end
      checks++; if (wce !== 13'd0) begin errors++; $display("FAIL reset_wce got %0d exp 0", wce); end
      checks++; if (sae !== 48'd0) begin errors++; $display("FAIL reset_sae got %0d exp 0", sae); end
      checks++; if (last_err !== 14'd0) begin errors++; $display("FAIL reset_last_err got %0h exp 0", last_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h exp 0", busy); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL reset_sat got %0h exp 0", sat); end
      in_valid = 1'b0;
      rst_n    = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %0h exp 1", in_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_single;
      send(12'd5, 12'd6, 13'd13);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0h exp 1", busy); end
      @(posedge clk);
      #1;
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL single_early_cnt got %0d exp 0", sample_cnt); end
      @(posedge clk);
      #1;
      checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL single_sample_cnt got %0d exp 1", sample_cnt); end
      checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL single_err_cnt got %0d exp 1", err_cnt); end
      checks++; if (wce !== 13'd2) begin errors++; $display("FAIL single_wce got %0d exp 2", wce); end
      checks++; if (sae !== 48'd2) begin errors++; $display("FAIL single_sae got %0d exp 2", sae); end
      checks++; if (last_err !== 14'd2) begin errors++; $display("FAIL single_last_err got %0h exp 2", last_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done got %0h exp 0", busy); end
   endtask

   task automatic test_hold;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (sample_cnt !== 32'd1) begin errors++; $display("FAIL hold_sample_cnt got %0d exp 1", sample_cnt); end
      checks++; if (sae !== 48'd2) begin errors++; $display("FAIL hold_sae got %0d exp 2", sae); end
   endtask

   task automatic test_back_to_back;
      logic [11:0] a;
      logic [11:0] b;
      pulse_clear();
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL b2b_cleared got %0d exp 0", sample_cnt); end
      for (int i = 0; i < 100; i++) begin
         a = 12'((i * 37) % 4096);
         b = 12'((i * 911 + 3) % 4096);
         send(a, b, {1'b0, a} + {1'b0, b});
      end
      send(12'd4095, 12'd4095, 13'd8186);
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_tail got %0h exp 1", busy); end
      @(posedge clk);
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_drop got %0h exp 0", busy); end
      checks++; if (sample_cnt !== 32'd101) begin errors++; $display("FAIL b2b_sample_cnt got %0d exp 101", sample_cnt); end
      checks++; if (err_cnt !== 32'd1) begin errors++; $display("FAIL b2b_err_cnt got %0d exp 1", err_cnt); end
      checks++; if (wce !== 13'd4) begin errors++; $display("FAIL b2b_wce got %0d exp 4", wce); end
      checks++; if (sae !== 48'd4) begin errors++; $display("FAIL b2b_sae got %0d exp 4", sae); end
      checks++; if (last_err !== 14'h3FFC) begin errors++; $display("FAIL b2b_last_err got %0h exp 3ffc", last_err); end
   endtask

   task automatic test_saturation;
      pulse_clear();
      for (int i = 0; i < 20; i++) begin
         send(12'd1, 12'd1, 13'd3);
      end
      drain();
      checks++; if (sample_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_sample_cnt got %0d exp 15", sample_cnt4); end
      checks++; if (err_cnt4 !== 4'd15) begin errors++; $display("FAIL sat_err_cnt got %0d exp 15", err_cnt4); end
      checks++; if (sat4 !== 1'b1) begin errors++; $display("FAIL sat_flag got %0h exp 1", sat4); end
      checks++; if (sae4 !== 48'd20) begin errors++; $display("FAIL sat_sae4 got %0d exp 20", sae4); end
      checks++; if (sample_cnt !== 32'd20) begin errors++; $display("FAIL wide_sample_cnt got %0d exp 20", sample_cnt); end
      checks++; if (sat !== 1'b0) begin errors++; $display("FAIL wide_sat got %0h exp 0", sat); end
      pulse_clear();
      checks++; if (sample_cnt4 !== 4'd0) begin errors++; $display("FAIL satclr_sample_cnt got %0d exp 0", sample_cnt4); end
      checks++; if (err_cnt4 !== 4'd0) begin errors++; $display("FAIL satclr_err_cnt got %0d exp 0", err_cnt4); end
      checks++; if (sat4 !== 1'b0) begin errors++; $display("FAIL satclr_flag got %0h exp 0", sat4); end
      checks++; if (wce4 !== 13'd0) begin errors++; $display("FAIL satclr_wce got %0d exp 0", wce4); end
   endtask

   task automatic test_clear_flush;
      send(12'd10, 12'd10, 13'd25);
      send(12'd10, 12'd10, 13'd26);
      in_valid = 1'b1;
      in_a     = 12'd1;
      in_b     = 12'd1;
      in_o     = 13'd9;
      clear    = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %0h exp 0", in_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy_before got %0h exp 1", busy); end
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after got %0h exp 0", busy); end
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL flush_sample_cnt got %0d exp 0", sample_cnt); end
      drain();
      checks++; if (sample_cnt !== 32'd0) begin errors++; $display("FAIL flush_sample_cnt_late got %0d exp 0", sample_cnt); end
      checks++; if (sae !== 48'd0) begin errors++; $display("FAIL flush_sae_late got %0d exp 0", sae); end
   endtask

`ifdef ADD_ERR_MON_MSE_EN
   task automatic test_mse;
      pulse_clear();
      send(12'd5, 12'd6, 13'd13);
      send(12'd4095, 12'd4095, 13'd8186);
      send(12'd1, 12'd2, 13'd3);
      drain();
      checks++; if (sse !== 96'd20) begin errors++; $display("FAIL mse_sse got %0d exp 20", sse); end
      checks++; if (sae !== 48'd6) begin errors++; $display("FAIL mse_sae got %0d exp 6", sae); end
      checks++; if (wce !== 13'd4) begin errors++; $display("FAIL mse_wce got %0d exp 4", wce); end
      checks++; if (err_cnt !== 32'd2) begin errors++; $display("FAIL mse_err_cnt got %0d exp 2", err_cnt); end
      checks++; if (last_err !== 14'd0) begin errors++; $display("FAIL mse_last_err got %0h exp 0", last_err); end
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single();
      test_hold();
      test_back_to_back();
      test_saturation();
      test_clear_flush();
`ifdef ADD_ERR_MON_MSE_EN
      test_mse();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/add_err_monitor.md
Name: add_err_monitor

Overview:
- Streaming checker at the output end of the approximate adders: consumes operand pairs plus the approximate sum, recomputes the exact sum, and accumulates error statistics.
- Statistics: sample count, error count (EP), worst-case error (WCE) and sum of absolute error (for MAE).
- Used in FPGA test harnesses and simulation to characterise any add<W>u approximate adder on live data.
- Fully pipelined: one sample per cycle.

Parameters:
- W, 12, operand width; the approximate sum is W+1 bits.
- CNT_W, 32, width of the sample and error counters.
- ACC_W, 48, width of the sum-of-absolute-error accumulator.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  monitor accepts a sample this cycle.
- in_a  in  W  operand A.
- in_b  in  W  operand B.
- in_o  in  W+1  approximate sum under test.
- clear  in  1  synchronous statistics clear, single-cycle pulse.
- sample_cnt  out  CNT_W  samples processed.
- err_cnt  out  CNT_W  samples with a nonzero error.
- wce  out  W+1  maximum absolute error seen.
- sae  out  ACC_W  sum of absolute errors.
- last_err  out  W+2  signed error (approx − exact) of the most recently retired sample.
- busy  out  1  a sample is in flight in the pipeline.
- sat  out  1  sticky flag: some counter or accumulator saturated.

Behaviour:
- Reset and interface:
  - One clock domain.
  - rst_n is asynchronous assert, synchronous deassert; all registers go to 0, so every output is 0 in reset.
  - Exception: in_ready = 0 while rst_n is low.
  - Handshake: a sample transfers when in_valid && in_ready.
  - in_ready = !clear. There is no other backpressure.
- Stage 1 (accept cycle):
  - Register the exact sum in_a + in_b (W+1 bits, zero-extended) and in_o.
  - Register v1 = transfer.
- Stage 2:
  - Signed diff d = {0,in_o} − {0,exact}, width W+2; abs e = |d|, width W+1.
  - Register d, e and v2 = v1.
- Retire (at the edge after stage 2, when v2 = 1):
  - sample_cnt += 1.
  - err_cnt += (e != 0).
  - wce = max(wce, e).
  - sae += e.
  - last_err = d.
- Latency: a sample accepted at edge N is visible in the statistics after edge N+2 (readable in cycle N+2). Back-to-back samples each retire one cycle apart.
- busy = v1 | v2.
- Saturation: counters and sae clamp at all-ones and never wrap; sat is set on any clamp event and stays set until clear or reset.
- clear:
  - The next edge zeroes all statistics, last_err, sat, v1 and v2, flushing in-flight samples.
  - The input is not accepted in the clear cycle.
  - clear dominates any simultaneous retire.
- in_valid low: the pipeline bubbles and the statistics hold.
- Reset mid-operation: in-flight samples are discarded.

Optional Feature:
- Macro: ADD_ERR_MON_MSE_EN.
- When defined:
  - Extra output sse [2*ACC_W-1:0], the sum of e*e, updated at retire.
  - Same saturation and clear rules as sae; sets sat on clamp.
  - The squarer is registered in stage 2, so latency is unchanged.
- When undefined: no sse port and no squarer logic.

Decomposition:
- Package add_err_pkg:
  - Default W, CNT_W, ACC_W localparams.
  - Saturating-add function sat_add.
  - Typedef err_t, signed W+2.
- One sub-module, add_err_absdiff: combinational; takes exact and approx, returns signed diff and abs error.
- All counters stay in the top module.

Test Plan:
- Reset: rst_n low for 3 cycles → all outputs 0, in_ready 0; after release → in_ready 1.
- Single sample a=5, b=6, o=13 → two cycles later: sample_cnt 1, err_cnt 1, wce 2, sae 2, last_err +2.
- 100 back-to-back samples with o = a+b exact, plus one with a=4095, b=4095, o=8186 (exact 8190) → sample_cnt 101, err_cnt 1, wce 4, last_err −4, busy drops 2 cycles after the last transfer.
- Saturation (CNT_W=4): 20 error samples → sample_cnt and err_cnt hold at 15, sat=1; then clear → all 0, sat=0.
- clear asserted while 2 samples are in flight with 1 new sample presented → in_ready 0 that cycle, all three samples dropped, sample_cnt 0 afterwards.
- With ADD_ERR_MON_MSE_EN: errors +2, −4, 0 → sse 20, sae 6, wce 4.
